// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared pipeline constants and IF/ID payload type
package mips_pipe_pkg;

    localparam int XLEN = 32;
    localparam int CTRL_W_DEF = 10;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic            valid;
    } ifid_word_t;

endpackage

// File: rtl/pipe_reg.sv
// rtl/pipe_reg.sv - enabled pipeline register with synchronous clear-to-value
module pipe_reg #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    // clear outranks enable so a flush lands even when the stage would load
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_q <= RST_VAL;
        end else if (clr_i) begin
            data_q <= CLR_VAL;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/fetch_stall_responder.sv
// rtl/fetch_stall_responder.sv - PC, IF/ID, ID/EX under stall control; FETCH_PERF_CNT_EN adds perf counters
module fetch_stall_responder
    import mips_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CTRL_W    = CTRL_W_DEF,
    parameter int          MAX_STALL = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_write_en,
    input  logic              ifid_write_en,
    input  logic              stall_flush,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    input  logic [31:0]       imem_rdata,
    input  logic [CTRL_W-1:0] id_ctrl_in,
    output logic [31:0]       imem_addr,
    output logic [31:0]       ifid_instr,
    output logic [31:0]       ifid_pc4,
    output logic              ifid_valid,
    output logic [CTRL_W-1:0] idex_ctrl,
    output logic              idex_valid,
    output logic              stall_timeout,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_count
);

    localparam int SCW = $clog2(MAX_STALL + 1);

    logic [XLEN-1:0] pc_q, pc_d, pc_plus4;
    logic            ifid_flush;
    ifid_word_t      ifid_d, ifid_q;
    logic [CTRL_W:0] idex_d, idex_q;
    logic [SCW-1:0]  stall_cnt_q, stall_cnt_d;
    logic            timeout_q, timeout_d;

    assign pc_plus4 = pc_q + PC_STEP;
    // a branch only squashes IF/ID when both the PC and IF/ID actually move
    assign ifid_flush = ifid_write_en && pc_write_en && branch_taken;

    always_comb begin
        pc_d = pc_q;
        if (pc_write_en) begin
            pc_d = branch_taken ? branch_target : pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign ifid_d = '{instr: imem_rdata, valid: 1'b1};

    pipe_reg #(
        .WIDTH   ($bits(ifid_word_t)),
        .RST_VAL ({NOP_INSTR, 1'b0}),
        .CLR_VAL ({NOP_INSTR, 1'b0})
    ) u_ifid_iv (
        .clk_i   (clk),
        .reset_i (reset),
        .en_i    (ifid_write_en),
        .clr_i   (ifid_flush),
        .d_i     (ifid_d),
        .q_o     (ifid_q)
    );

    // pc4 survives a flush, so it has its own enable rather than the clear
    pipe_reg #(
        .WIDTH   (XLEN)
    ) u_ifid_pc4 (
        .clk_i   (clk),
        .reset_i (reset),
        .en_i    (ifid_write_en && !ifid_flush),
        .clr_i   (1'b0),
        .d_i     (pc_plus4),
        .q_o     (ifid_pc4)
    );

    assign idex_d = {id_ctrl_in, ifid_q.valid};

    pipe_reg #(
        .WIDTH   (CTRL_W + 1)
    ) u_idex (
        .clk_i   (clk),
        .reset_i (reset),
        .en_i    (1'b1),
        .clr_i   (stall_flush),
        .d_i     (idex_d),
        .q_o     (idex_q)
    );

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (pc_write_en) begin
            stall_cnt_d = '0;
        end else if (stall_cnt_q != SCW'(MAX_STALL)) begin
            stall_cnt_d = stall_cnt_q + SCW'(1);
        end
        timeout_d = timeout_q || (stall_cnt_d == SCW'(MAX_STALL));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles_q, flush_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (!pc_write_en && (stall_cycles_q != 32'hFFFF_FFFF)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (ifid_flush && (flush_count_q != 32'hFFFF_FFFF)) begin
                flush_count_q <= flush_count_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

    assign imem_addr     = pc_q;
    assign ifid_instr    = ifid_q.instr;
    assign ifid_valid    = ifid_q.valid;
    assign idex_ctrl     = idex_q[CTRL_W:1];
    assign idex_valid    = idex_q[0];
    assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_fetch_stall_responder.sv
// tb/tb_fetch_stall_responder.sv - directed and random checks against a behavioural model
module tb_fetch_stall_responder;

    localparam int CTRL_W    = 10;
    localparam int MAX_STALL = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              pc_write_en;
    logic              ifid_write_en;
    logic              stall_flush;
    logic              branch_taken;
    logic [31:0]       branch_target;
    logic [31:0]       imem_rdata;
    logic [CTRL_W-1:0] id_ctrl_in;
    logic [31:0]       imem_addr;
    logic [31:0]       ifid_instr;
    logic [31:0]       ifid_pc4;
    logic              ifid_valid;
    logic [CTRL_W-1:0] idex_ctrl;
    logic              idex_valid;
    logic              stall_timeout;
    logic [31:0]       stall_cycles;
    logic [31:0]       flush_count;

    int n_chk  = 0;
    int n_fail = 0;

    // behavioural model state
    logic [31:0]       m_pc;
    logic [31:0]       m_instr;
    logic [31:0]       m_pc4;
    logic              m_ifv;
    logic [CTRL_W-1:0] m_ctrl;
    logic              m_exv;
    int                m_run;
    logic              m_to;
    longint            m_stalls;
    longint            m_flushes;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0001;
    endfunction

    assign imem_rdata = imem_word(imem_addr);

    fetch_stall_responder #(
        .RESET_PC  (32'h0000_0000),
        .CTRL_W    (CTRL_W),
        .MAX_STALL (MAX_STALL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_write_en   (pc_write_en),
        .ifid_write_en (ifid_write_en),
        .stall_flush   (stall_flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_rdata    (imem_rdata),
        .id_ctrl_in    (id_ctrl_in),
        .imem_addr     (imem_addr),
        .ifid_instr    (ifid_instr),
        .ifid_pc4      (ifid_pc4),
        .ifid_valid    (ifid_valid),
        .idex_ctrl     (idex_ctrl),
        .idex_valid    (idex_valid),
        .stall_timeout (stall_timeout),
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat32(input longint v);
        return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    task automatic model_edge();
        logic [31:0] pc_n;
        logic        take;
        if (reset) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_ifv = 1'b0;
            m_ctrl = '0; m_exv = 1'b0; m_run = 0; m_to = 1'b0;
            m_stalls = 0; m_flushes = 0;
            return;
        end
        take = pc_write_en && branch_taken;
        pc_n = !pc_write_en ? m_pc : (branch_taken ? branch_target : m_pc + 32'd4);
        m_exv  = stall_flush ? 1'b0 : m_ifv;
        m_ctrl = stall_flush ? '0 : id_ctrl_in;
        if (ifid_write_en) begin
            if (take) begin
                m_instr = 32'h0;
                m_ifv = 1'b0;
                m_flushes++;
            end else begin
                m_instr = imem_word(m_pc);
                m_pc4 = m_pc + 32'd4;
                m_ifv = 1'b1;
            end
        end
        if (pc_write_en) begin
            m_run = 0;
        end else begin
            m_run = (m_run < MAX_STALL) ? m_run + 1 : MAX_STALL;
            m_stalls++;
        end
        if (m_run == MAX_STALL) m_to = 1'b1;
        m_pc = pc_n;
    endtask

    task automatic check_all();
        chk("imem_addr", imem_addr, m_pc);
        chk("ifid_instr", ifid_instr, m_instr);
        chk("ifid_pc4", ifid_pc4, m_pc4);
        chk("ifid_valid", 32'(ifid_valid), 32'(m_ifv));
        chk("idex_ctrl", 32'(idex_ctrl), 32'(m_ctrl));
        chk("idex_valid", 32'(idex_valid), 32'(m_exv));
        chk("stall_timeout", 32'(stall_timeout), 32'(m_to));
`ifdef FETCH_PERF_CNT_EN
        chk("stall_cycles", stall_cycles, sat32(m_stalls));
        chk("flush_count", flush_count, sat32(m_flushes));
`else
        chk("stall_cycles", stall_cycles, 32'h0);
        chk("flush_count", flush_count, 32'h0);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input logic rst, input logic pwe, input logic iwe, input logic sf,
                         input logic bt, input logic [31:0] tgt);
        reset = rst; pc_write_en = pwe; ifid_write_en = iwe; stall_flush = sf;
        branch_taken = bt; branch_target = tgt;
        id_ctrl_in = CTRL_W'($urandom);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] fc_before;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        m_pc = 'x;
        step();
        chk("reset_pc", imem_addr, 32'h0);
        chk("reset_ifid_valid", 32'(ifid_valid), 32'h0);

        // free-running fetch
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        chk("free_pc8", imem_addr, 32'h8);
        chk("free_pc4_8", ifid_pc4, 32'h8);

        // one-cycle load-use stall at PC=8
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        step();
        chk("stall_pc_hold", imem_addr, 32'h8);
        chk("stall_ifid_hold", ifid_instr, imem_word(32'h4));
        chk("stall_bubble", 32'(idex_valid), 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        chk("resume_pc12", imem_addr, 32'hC);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        chk("pc16", imem_addr, 32'h10);

        // taken branch at PC=0x10
        fc_before = flush_count;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h40);
        step();
        chk("br_pc", imem_addr, 32'h40);
        chk("br_ifid_valid", 32'(ifid_valid), 32'h0);
        chk("br_ifid_instr", ifid_instr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("br_flush_count", flush_count, fc_before + 32'd1);
`endif

        // branch ignored while the PC is held
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h80);
        step();
        chk("br_held_pc", imem_addr, 32'h40);
        chk("br_held_valid", 32'(ifid_valid), 32'h1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step();

        // watchdog: 15 consecutive stalls
        for (int i = 1; i <= MAX_STALL; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
            step();
            chk("wd_level", 32'(stall_timeout), (i == MAX_STALL) ? 32'h1 : 32'h0);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        chk("wd_sticky", 32'(stall_timeout), 32'h1);

        // reset in the middle of a stall with IF/ID valid
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
        step();
        chk("rst_pc", imem_addr, 32'h0);
        chk("rst_valid", 32'(ifid_valid), 32'h0);
        chk("rst_timeout", 32'(stall_timeout), 32'h0);

        // PC wrap at the top of the address space
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        chk("wrap_pc", imem_addr, 32'h0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            drive(($urandom_range(99) < 2), ($urandom_range(99) < 75), ($urandom_range(99) < 80),
                  ($urandom_range(99) < 20), ($urandom_range(99) < 15),
                  (r[0] ? 32'hFFFF_FFF8 : {r[31:2], 2'b00}));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
